// File: rtl/sram_cmd_responder.sv
// sram_cmd_responder
//   Receives 5-byte command frames from a UART receiver. Byte 0 is the opcode
//   and bytes 1-4 are a 32-bit operand, MSB first. An executor FSM performs
//   each command: it updates the address and write-data registers, issues
//   SRAM read and write requests, and sends reply bytes through the UART
//   transmitter.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   tx_data, tx_start     byte and transmit request to the UART transmitter
//   tx_ready              transmitter idle / accepting
//   sram_addr             current SRAM address register
//   sram_data_write       write-data register
//   sram_we, sram_re      one-cycle write / read request pulses
//   sram_busy             SRAM driver busy with an access
//   sram_data_read        read data, valid when sram_busy falls
//   overrun               one-cycle pulse when a complete frame is dropped
module sram_cmd_responder #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ID_WORD        = 32'h2604_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [31:0] sram_addr,
  output logic [7:0]  sram_data_write,
  output logic        sram_we,
  output logic        sram_re,
  input  logic        sram_busy,
  input  logic [7:0]  sram_data_read,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_ADDR     = 8'h01;
  localparam logic [7:0] OP_LOAD     = 8'h02;
  localparam logic [7:0] OP_WRITE    = 8'h03;
  localparam logic [7:0] OP_READ     = 8'h04;
  localparam logic [7:0] OP_READ_REQ = 8'h05;
  localparam logic [7:0] OP_COUNT    = 8'h06;
  localparam logic [7:0] OP_CONST    = 8'h07;

  typedef enum logic [2:0] {IDLE, EXEC, WR_WAIT, RD_WAIT, TX_LOAD, TX_HOLD} state_t;

  // ---------------- frame assembly ----------------
  logic [2:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    asm_op;
  logic [23:0]   asm_arg;
  logic          frame_done;
  logic          pend_valid;
  logic [7:0]    pend_op;
  logic [31:0]   pend_arg;
  logic          pop;
  state_t        state_q, state_d;

  assign frame_done = rx_valid && (byte_cnt == 3'd4);
  assign pop        = (state_q == IDLE) && pend_valid;

  // NOTE: every register in a clocked block is assigned with <=, so all of
  // them update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      asm_op     <= '0;
      asm_arg    <= '0;
      pend_valid <= 1'b0;
      pend_op    <= '0;
      pend_arg   <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid) begin
        tmo_cnt <= '0;
        if (byte_cnt == 3'd0) asm_op <= rx_data;
        else                  asm_arg <= {asm_arg[15:0], rx_data};
        byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
      end else if (byte_cnt != 3'd0) begin
        // This is the TIMEOUT_CYCLES-th consecutive idle cycle: drop the partial frame.
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          byte_cnt <= '0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end

      // A pop in the same cycle frees the slot, so the new frame is not an overrun.
      if (frame_done) begin
        if (pend_valid && !pop) begin
          overrun <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_op    <= asm_op;
          pend_arg   <= {asm_arg, rx_data};
        end
      end else if (pop) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // ---------------- executor ----------------
  logic [7:0]  cur_op, cur_op_d;
  logic [31:0] cur_arg, cur_arg_d;
  logic [31:0] sram_addr_d;
  logic [7:0]  sram_data_write_d, rdata, rdata_d, tx_data_d;
  logic        tx_start_d, sram_we_d, sram_re_d, seen_busy, seen_busy_d;
  logic [31:0] tx_buf, tx_buf_d;
  logic [1:0]  tx_left, tx_left_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cur_op          <= '0;
      cur_arg         <= '0;
      sram_addr       <= '0;
      sram_data_write <= '0;
      rdata           <= '0;
      tx_data         <= '0;
      tx_start        <= 1'b0;
      sram_we         <= 1'b0;
      sram_re         <= 1'b0;
      seen_busy       <= 1'b0;
      tx_buf          <= '0;
      tx_left         <= '0;
    end else begin
      state_q         <= state_d;
      cur_op          <= cur_op_d;
      cur_arg         <= cur_arg_d;
      sram_addr       <= sram_addr_d;
      sram_data_write <= sram_data_write_d;
      rdata           <= rdata_d;
      tx_data         <= tx_data_d;
      tx_start        <= tx_start_d;
      sram_we         <= sram_we_d;
      sram_re         <= sram_re_d;
      seen_busy       <= seen_busy_d;
      tx_buf          <= tx_buf_d;
      tx_left         <= tx_left_d;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    cur_op_d          = cur_op;
    cur_arg_d         = cur_arg;
    sram_addr_d       = sram_addr;
    sram_data_write_d = sram_data_write;
    rdata_d           = rdata;
    tx_data_d         = tx_data;
    tx_start_d        = tx_start;
    sram_we_d         = 1'b0;
    sram_re_d         = 1'b0;
    seen_busy_d       = seen_busy;
    tx_buf_d          = tx_buf;
    tx_left_d         = tx_left;

    unique case (state_q)
      IDLE: begin
        if (pend_valid) begin
          cur_op_d  = pend_op;
          cur_arg_d = pend_arg;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        state_d = IDLE;
        case (cur_op)
          OP_ADDR:  sram_addr_d       = cur_arg;
          OP_LOAD:  sram_data_write_d = cur_arg[7:0];
          OP_COUNT: sram_addr_d       = sram_addr + 32'd1;
          OP_WRITE, OP_READ_REQ: begin
            // Hold in EXEC until the driver is free; the pulse is one cycle.
            if (sram_busy) begin
              state_d = EXEC;
            end else begin
              sram_we_d   = (cur_op == OP_WRITE);
              sram_re_d   = (cur_op == OP_READ_REQ);
              seen_busy_d = 1'b0;
              state_d     = (cur_op == OP_WRITE) ? WR_WAIT : RD_WAIT;
            end
          end
          OP_READ: begin
            tx_data_d = rdata;
            tx_left_d = 2'd0;
            state_d   = TX_LOAD;
          end
          OP_CONST: begin
            tx_data_d = ID_WORD[31:24];
            tx_buf_d  = {ID_WORD[23:0], 8'h00};
            tx_left_d = 2'd3;
            state_d   = TX_LOAD;
          end
          default: ;
        endcase
      end

      WR_WAIT, RD_WAIT: begin
        if (sram_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy) begin
          if (state_q == RD_WAIT) rdata_d = sram_data_read;
          state_d = IDLE;
        end
      end

      TX_LOAD: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          state_d    = TX_HOLD;
        end
      end

      TX_HOLD: begin
        // The transmitter drops tx_ready once it has taken the byte.
        if (!tx_ready) begin
          tx_start_d = 1'b0;
          if (tx_left != 2'd0) begin
            tx_data_d = tx_buf[31:24];
            tx_buf_d  = {tx_buf[23:0], 8'h00};
            tx_left_d = tx_left - 2'd1;
            state_d   = TX_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_cmd_responder.sv
module tb_sram_cmd_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready = 1'b1;
  logic [31:0] sram_addr;
  logic [7:0]  sram_data_write;
  logic        sram_we, sram_re;
  logic        sram_busy = 1'b0;
  logic [7:0]  sram_data_read = 8'hAA;
  logic        overrun;

  always #5 clk = ~clk;

  sram_cmd_responder dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .sram_addr(sram_addr), .sram_data_write(sram_data_write),
    .sram_we(sram_we), .sram_re(sram_re), .sram_busy(sram_busy),
    .sram_data_read(sram_data_read), .overrun(overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: expected transmitted bytes and expected write data, in order.
  logic [7:0] tx_exp[$];
  logic [7:0] we_exp[$];
  int tx_acc = 0, re_seen = 0, re_exp = 0, ovr_seen = 0, ovr_exp = 0;
  int uart_cnt = 0, sram_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor plus UART/SRAM peer models, all on the falling edge.
  always @(negedge clk) begin
    // UART transmitter: accepts a byte, stays busy for 12 cycles.
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) tx_ready = 1'b1;
    end else if (tx_start && tx_ready) begin
      tx_acc++;
      if (tx_exp.size() == 0) check("tx_unexpected_byte", 32'(tx_exp.size()), 32'd1);
      else                    check("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
      tx_ready = 1'b0;
      uart_cnt = 12;
    end

    // SRAM driver: each request keeps it busy for 3 cycles.
    if (sram_we || sram_re) begin
      check("we_re_exclusive", {31'h0, sram_we & sram_re}, 32'd0);
      check("req_while_busy", {31'h0, sram_busy}, 32'd0);
      if (sram_re) re_seen++;
      if (sram_we) begin
        if (we_exp.size() == 0) check("we_unexpected", 32'(we_exp.size()), 32'd1);
        else                    check("we_data", {24'h0, sram_data_write}, {24'h0, we_exp.pop_front()});
      end
      sram_busy = 1'b1;
      sram_cnt  = 3;
    end else if (sram_cnt > 0) begin
      sram_cnt--;
      if (sram_cnt == 0) sram_busy = 1'b0;
    end

    if (overrun) ovr_seen++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] arg);
    send_byte(op);
    send_byte(arg[31:24]);
    send_byte(arg[23:16]);
    send_byte(arg[15:8]);
    send_byte(arg[7:0]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_acc < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_acc < target) check("tx_wait_timeout", 32'(tx_acc), 32'(target));
  endtask

  initial begin
    int tgt;
    wait_cycles(3);
    reset = 1'b0;
    // Reset state
    check("rst_addr", sram_addr, 32'h0);
    check("rst_wdata", {24'h0, sram_data_write}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_we", {31'h0, sram_we}, 32'h0);
    check("rst_re", {31'h0, sram_re}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);

    // ADDR, LOAD, WRITE
    send_frame(8'h01, 32'h0000_0001);
    send_frame(8'h02, 32'h0000_0001);
    we_exp.push_back(8'h01);
    send_frame(8'h03, 32'h0000_0000);
    wait_cycles(20);
    check("write_addr", sram_addr, 32'h1);
    check("write_wdata", {24'h0, sram_data_write}, 32'h1);
    check("write_pulses_done", 32'(we_exp.size()), 32'd0);

    // READ_REQ then READ
    re_exp++;
    send_frame(8'h05, 32'h0);
    tx_exp.push_back(8'hAA);
    send_frame(8'h04, 32'h0);
    wait_tx(1, 200);
    wait_cycles(20);
    check("read_req_pulses", 32'(re_seen), 32'(re_exp));

    // CONST
    tx_exp.push_back(8'h26); tx_exp.push_back(8'h04);
    tx_exp.push_back(8'h00); tx_exp.push_back(8'h01);
    send_frame(8'h07, 32'h0);
    wait_tx(5, 400);
    wait_cycles(20);

    // COUNT wrap and ignored opcode
    send_frame(8'h01, 32'hFFFF_FFFF);
    send_frame(8'h06, 32'h0);
    wait_cycles(10);
    check("count_wrap", sram_addr, 32'h0);
    send_frame(8'hEE, 32'h1234_5678);
    wait_cycles(10);
    check("bad_op_addr", sram_addr, 32'h0);
    check("bad_op_wdata", {24'h0, sram_data_write}, 32'h1);

    // Two frames during CONST transmit: first queued, second dropped
    tx_exp.push_back(8'h26); tx_exp.push_back(8'h04);
    tx_exp.push_back(8'h00); tx_exp.push_back(8'h01);
    send_frame(8'h07, 32'h0);
    send_frame(8'h01, 32'hCAFE_BABE);
    ovr_exp++;
    send_frame(8'h01, 32'h1111_1111);
    wait_tx(9, 400);
    wait_cycles(30);
    check("queued_frame_addr", sram_addr, 32'hCAFE_BABE);
    check("overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));

    // Partial-frame timeout
    send_byte(8'h01);
    send_byte(8'hAB);
    wait_cycles(4097);
    send_frame(8'h01, 32'h1234_5678);
    wait_cycles(10);
    check("timeout_addr", sram_addr, 32'h1234_5678);

    // Reset during transmit abandons the remaining bytes
    tx_exp.push_back(8'h26);
    tgt = tx_acc + 1;
    send_frame(8'h07, 32'h0);
    wait_tx(tgt, 200);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(150);
    check("reset_abandon_tx", 32'(tx_acc), 32'(tgt));
    check("reset_addr", sram_addr, 32'h0);

    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    check("final_read_pulses", 32'(re_seen), 32'(re_exp));
    check("final_overruns", 32'(ovr_seen), 32'(ovr_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_cmd_responder.md
SRAM_CMD_RESPONDER -- requirements
Module: sram_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, idle cycles after which a partial frame is discarded.
REQ-002 SHALL have parameter ID_WORD, default 32'h2604_0001, constant returned by the CONST opcode.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-008 SHALL have port tx_start  output  1  transmit request to UART transmitter.
REQ-009 SHALL have port tx_ready  input  1  transmitter idle/accepting.
REQ-010 SHALL have port sram_addr  output  32  current SRAM address register.
REQ-011 SHALL have port sram_data_write  output  8  write-data register.
REQ-012 SHALL have port sram_we  output  1  one-cycle write request pulse.
REQ-013 SHALL have port sram_re  output  1  one-cycle read request pulse.
REQ-014 SHALL have port sram_busy  input  1  SRAM driver busy with an access.
REQ-015 SHALL have port sram_data_read  input  8  data from SRAM driver, valid when sram_busy falls.
REQ-016 SHALL have port overrun  output  1  one-cycle pulse when a complete frame is dropped.

Function
REQ-017 SHALL assemble frames of 5 rx bytes: byte0 opcode, bytes1-4 32-bit operand, MSB first.
REQ-018 SHALL use a 3-bit byte counter 0..4; on 5th byte, counter returns to 0 and frame is complete.
REQ-019 SHALL discard a partial frame (counter to 0) when TIMEOUT_CYCLES consecutive cycles pass with counter non-zero and no rx_valid.
REQ-020 SHALL place a complete frame in a one-deep pending register; if pending is full at completion, new frame is dropped and overrun pulses that cycle.
REQ-021 SHALL run an executor FSM with states IDLE, EXEC, WR_WAIT, RD_WAIT, TX_LOAD, TX_HOLD; frame assembly continues in every state.
REQ-022 IDLE: pending full -> pop into EXEC next cycle; pop and a simultaneous frame completion -> completed frame occupies pending, no overrun.
REQ-023 Opcode 0x01 ADDR: sram_addr <= operand; 0x02 LOAD: sram_data_write <= operand[7:0]; both return to IDLE.
REQ-024 Opcode 0x03 WRITE: wait for sram_busy=0, pulse sram_we one cycle, enter WR_WAIT until sram_busy seen 1 then 0, then IDLE.
REQ-025 Opcode 0x05 READ_REQ: wait for sram_busy=0, pulse sram_re one cycle, enter RD_WAIT; on cycle sram_busy seen falling, latch sram_data_read into internal rdata; IDLE.
REQ-026 Opcode 0x04 READ: transmit 1 byte, rdata.
REQ-027 Opcode 0x06 COUNT: sram_addr <= sram_addr + 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-028 Opcode 0x07 CONST: transmit 4 bytes of ID_WORD, MSB first.
REQ-029 Any other opcode SHALL be ignored (no output change), return to IDLE.
REQ-030 TX_LOAD: drive tx_data, wait tx_ready=1, assert tx_start; TX_HOLD: hold tx_start and tx_data until tx_ready sampled 0, then deassert; next byte or IDLE.
REQ-031 tx_start SHALL never assert while tx_ready=0 on entry to TX_LOAD; each byte is sent exactly once.
REQ-032 sram_we and sram_re SHALL never assert together, and never while sram_busy=1.
REQ-033 Operand bytes of unused fields (e.g. WRITE operand) SHALL be ignored.

Reset
REQ-034 On reset=1 at a clock edge: sram_addr=0, sram_data_write=0, rdata=0, tx_data=0, tx_start=0, sram_we=0, sram_re=0, overrun=0, byte counter=0, timeout counter=0, pending empty, FSM=IDLE.
REQ-035 Reset mid-frame or mid-transmit SHALL abandon the operation with no further tx_start/sram pulse from it.

Verification
REQ-036 Frames {01,00000001},{02,00000001},{03,00000000} -> sram_addr=1, sram_data_write=0x01, exactly one sram_we pulse.
REQ-037 sram_data_read=0xAA; frames {05,0},{04,0} -> one sram_re pulse, then one UART byte 0xAA.
REQ-038 Frame {07,0} -> UART bytes 0x26,0x04,0x00,0x01 in order, one tx_start per byte.
REQ-039 sram_addr=0xFFFFFFFF then {06,0} -> sram_addr=0; opcode 0xEE -> no output change.
REQ-040 Send 2 bytes, idle TIMEOUT_CYCLES+1, then full {01,12345678} -> sram_addr=0x12345678.
REQ-041 During CONST transmit, send two more complete frames -> first executes after, second dropped with one overrun pulse.
